// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the eight-way round-robin arbiter: sizes and FSM state encoding.
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_8_dec_3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; a low enable yields all zeros.
module dec_3to8
    import rr_arbiter_8_pkg::*;
(
    input  logic [ID_W-1:0]    idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with bounded tenure; all outputs are registered.
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                gnt_valid
);

    localparam int HC_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [HC_W-1:0]     hold_cnt, hold_nxt;
    logic [ID_W-1:0]     id_nxt;
    logic                valid_nxt;
    logic [NUM_REQ-1:0]  gnt_nxt;
    logic [NUM_REQ-1:0]  others;
    logic [ID_W-1:0]     ptr_after;
    logic [ID_W:0]       pick_idle;
    logic [ID_W:0]       pick_masked;

    // Returns {found, index}: rotate so bit ptr lands at position 0, take the
    // lowest set bit, then add ptr back modulo 8.
    function automatic logic [ID_W:0] find_winner(input logic [NUM_REQ-1:0] r,
                                                  input logic [ID_W-1:0]    p);
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        logic [ID_W-1:0]      off;
        logic [ID_W-1:0]      idx;
        logic                 found;
        dbl   = {r, r} >> p;
        rot   = dbl[NUM_REQ-1:0];
        found = 1'b0;
        off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off   = k[ID_W-1:0];
            end
        end
        idx = p + off;
        return {found, idx};
    endfunction

    assign others      = req & ~(NUM_REQ'(1) << gnt_id);
    assign ptr_after   = gnt_id + 3'd1;
    assign pick_idle   = find_winner(req, ptr);
    assign pick_masked = find_winner(others, ptr_after);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        id_nxt    = gnt_id;
        valid_nxt = gnt_valid;
        case (state)
            IDLE: begin
                if (pick_idle[ID_W]) begin
                    state_nxt = GRANT;
                    id_nxt    = pick_idle[ID_W-1:0];
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    ptr_nxt = ptr_after;
                    if (pick_masked[ID_W]) begin
                        id_nxt   = pick_masked[ID_W-1:0];
                        hold_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                        valid_nxt = 1'b0;
                    end
                end else if (hold_cnt == HOLD_LAST) begin
                    // At the limit with nobody waiting, the count simply stays saturated.
                    if (|others) begin
                        ptr_nxt  = ptr_after;
                        id_nxt   = pick_masked[ID_W-1:0];
                        hold_nxt = '0;
                    end
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    dec_3to8 u_dec (
        .idx    (id_nxt),
        .en     (valid_nxt),
        .onehot (gnt_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            gnt       <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            gnt_id    <= id_nxt;
            gnt_valid <= valid_nxt;
            gnt       <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: three instances (MAX_HOLD 16, 1, 4) share clock, reset and requests.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt_o [3];
    logic [2:0] id_o  [3];
    logic       vld_o [3];

    int checks = 0;
    int errors = 0;

    rr_arbiter_8 #(.MAX_HOLD(16)) u_h16 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_o[0]), .gnt_id(id_o[0]), .gnt_valid(vld_o[0])
    );
    rr_arbiter_8 #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_o[1]), .gnt_id(id_o[1]), .gnt_valid(vld_o[1])
    );
    rr_arbiter_8 #(.MAX_HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt_o[2]), .gnt_id(id_o[2]), .gnt_valid(vld_o[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns the resource, how many cycles it has owned it,
    // and where the next search starts.
    bit m_vld [3];
    int m_id  [3];
    int m_ptr [3];
    int m_ten [3];

    function automatic int hold_of(input int i);
        if (i == 0) return 16;
        if (i == 1) return 1;
        return 4;
    endfunction

    function automatic int search(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_vld[i] = 0; m_id[i] = 0; m_ptr[i] = 0; m_ten[i] = 0;
        end
    endtask

    task automatic model_step(input logic [7:0] r);
        int o;
        int w;
        logic [7:0] masked;
        for (int i = 0; i < 3; i++) begin
            o = m_id[i];
            masked = r;
            masked[o] = 1'b0;
            if (!m_vld[i]) begin
                w = search(r, m_ptr[i]);
                if (w >= 0) begin
                    m_vld[i] = 1; m_id[i] = w; m_ten[i] = 1;
                end
            end else if (!r[o]) begin
                m_ptr[i] = (o + 1) % 8;
                w = search(masked, m_ptr[i]);
                if (w >= 0) begin
                    m_id[i] = w; m_ten[i] = 1;
                end else begin
                    m_vld[i] = 0;
                end
            end else if (m_ten[i] >= hold_of(i) && masked != 8'h00) begin
                m_ptr[i] = (o + 1) % 8;
                m_id[i]  = search(masked, m_ptr[i]);
                m_ten[i] = 1;
            end else begin
                m_ten[i] = m_ten[i] + 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive req, advance one rising edge (model follows), sample on the falling edge.
    task automatic tick(input logic [7:0] r);
        req = r;
        @(posedge clk);
        if (rst_n) model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_gnt", 32'(gnt_o[i]), 32'h0);
            chk("reset_vld", 32'(vld_o[i]), 32'h0);
            chk("reset_id",  32'(id_o[i]),  32'h0);
        end
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        int         inst;
        logic [7:0] req;
        logic       vld;
        logic [2:0] id;
        logic [7:0] gnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input int inst, input logic [7:0] r,
                       input logic vld, input logic [2:0] id, input logic [7:0] g);
        vec_t v;
        v.rst = rst; v.inst = inst; v.req = r; v.vld = vld; v.id = id; v.gnt = g;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'h00;
        model_reset();
        @(negedge clk);

        // Idle after reset
        for (int k = 0; k < 10; k++) add(k == 0, 0, 8'h00, 1'b0, 3'd0, 8'h00);
        // Single requester then release; the next search starts at 4
        for (int k = 0; k < 5; k++) add(k == 0, 0, 8'h08, 1'b1, 3'd3, 8'h08);
        add(0, 0, 8'h00, 1'b0, 3'd3, 8'h00);
        add(0, 0, 8'hFF, 1'b1, 3'd4, 8'h10);
        // MAX_HOLD=1 rotation
        for (int k = 0; k < 9; k++) add(k == 0, 1, 8'hFF, 1'b1, 3'(k % 8), 8'(1 << (k % 8)));
        // MAX_HOLD=4 timeout alternation
        for (int k = 0; k < 12; k++) add(k == 0, 2, 8'h03, 1'b1, 3'((k / 4) % 2), 8'(1 << ((k / 4) % 2)));
        // MAX_HOLD=4 uncontended saturation, then a newcomer wins next edge
        for (int k = 0; k < 10; k++) add(k == 0, 2, 8'h20, 1'b1, 3'd5, 8'h20);
        add(0, 2, 8'h21, 1'b1, 3'd0, 8'h01);

        foreach (vecs[n]) begin
            if (vecs[n].rst) do_reset();
            tick(vecs[n].req);
            chk($sformatf("vec%0d_gnt", n), 32'(gnt_o[vecs[n].inst]), 32'(vecs[n].gnt));
            chk($sformatf("vec%0d_vld", n), 32'(vld_o[vecs[n].inst]), 32'(vecs[n].vld));
            if (vecs[n].vld)
                chk($sformatf("vec%0d_id", n), 32'(id_o[vecs[n].inst]), 32'(vecs[n].id));
        end

        // Async reset mid-tenure, then a fresh search from 0
        do_reset();
        tick(8'h40);
        chk("async_pre_gnt", 32'(gnt_o[0]), 32'h40);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_gnt", 32'(gnt_o[0]), 32'h00);
        chk("async_vld", 32'(vld_o[0]), 32'h0);
        chk("async_id",  32'(id_o[0]),  32'h0);
        #1 rst_n = 1'b1;
        tick(8'hC0);
        chk("async_after_id",  32'(id_o[0]),  32'd6);
        chk("async_after_gnt", 32'(gnt_o[0]), 32'h40);

        // Randomized phase against the reference model
        do_reset();
        r = 8'h00;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 7))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom);
                2:       r = 8'h00;
                3, 4:    r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
                default: r = r;
            endcase
            tick(r);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rnd_vld%0d", i), 32'(vld_o[i]), 32'(m_vld[i]));
                chk($sformatf("rnd_id%0d", i),  32'(id_o[i]),  32'(m_id[i]));
                chk($sformatf("rnd_gnt%0d", i), 32'(gnt_o[i]),
                    m_vld[i] ? (32'h1 << m_id[i]) : 32'h0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
